// File: rtl/collision_scanner_if.sv
// Frame snapshot inputs and collision verdict outputs between position generators and game logic.
// Registered outputs only; no backpressure (frame_tick is a fire-and-forget pulse).
interface collision_scanner_if #(
    parameter int N_TUBES = 3,
    parameter int W       = 10
);
    localparam int IW = (N_TUBES > 1) ? $clog2(N_TUBES) : 1;

    logic                 frame_tick;
    logic                 restart;
    logic [W-1:0]         bird_y;
    logic [N_TUBES*W-1:0] tube_x;
    logic [N_TUBES*W-1:0] tube_y;
    logic                 busy;
    logic                 scan_done;
    logic                 game_end;
    logic [IW-1:0]        hit_idx;
    logic [1:0]           hit_cause;

    modport master (
        output frame_tick, restart, bird_y, tube_x, tube_y,
        input  busy, scan_done, game_end, hit_idx, hit_cause
    );

    modport slave (
        input  frame_tick, restart, bird_y, tube_x, tube_y,
        output busy, scan_done, game_end, hit_idx, hit_cause
    );
endinterface

// File: rtl/collision_scanner.sv
// Time-multiplexed bird/tube/ceiling/floor collision check, one tube per clock, sticky game_end.
// Latency N_TUBES+1 cycles tick-to-scan_done; ticks while busy or game over are dropped, not queued.
module collision_scanner #(
    parameter int N_TUBES     = 3,
    parameter int W           = 10,
    parameter int BIRD_X      = 364,
    parameter int BIRD_HALF   = 15,
    parameter int TUBE_HALF_W = 30,
    parameter int GAP_HALF    = 30,
    parameter int Y_MAX       = 479
) (
    input logic               clk,
    input logic               clr_n,
    collision_scanner_if.slave bus
);
    localparam int IW = (N_TUBES > 1) ? $clog2(N_TUBES) : 1;
    localparam int XW = W + 2;

    localparam logic [XW-1:0] BH      = XW'(BIRD_HALF);
    localparam logic [XW-1:0] GH      = XW'(GAP_HALF);
    localparam logic [XW-1:0] YM      = XW'(Y_MAX);
    localparam logic [XW-1:0] BX      = XW'(BIRD_X);
    localparam logic [XW-1:0] X_REACH = XW'(BIRD_HALF + TUBE_HALF_W);
    localparam logic [XW-1:0] X_HI    = XW'(BIRD_X + BIRD_HALF + TUBE_HALF_W);
    localparam logic [IW-1:0] LAST    = IW'(N_TUBES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE, OVER} state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         by_q, by_d;
    logic [N_TUBES*W-1:0] tx_q, tx_d, ty_q, ty_d;
    logic [IW-1:0]        idx_q, idx_d, pend_idx_q, pend_idx_d;
    logic                 tube_acc_q, tube_acc_d;
    logic                 ceil_q, ceil_d, floor_q, floor_d;
    logic                 busy_q, busy_d, scan_done_q, scan_done_d, game_end_q, game_end_d;
    logic [IW-1:0]        hit_idx_q, hit_idx_d;
    logic [1:0]           hit_cause_q, hit_cause_d;

    logic [XW-1:0] tx_w, ty_w, by_w;
    logic          x_ovl, y_out, tube_hit, ceil_hit, floor_hit;

    // Widened, subtraction-free compares so coordinates near zero never wrap.
    always_comb begin
        tx_w      = {2'b00, tx_q[idx_q*W +: W]};
        ty_w      = {2'b00, ty_q[idx_q*W +: W]};
        by_w      = {2'b00, by_q};
        x_ovl     = (X_HI >= tx_w) && (tx_w + X_REACH >= BX);
        y_out     = (by_w + BH >= ty_w + GH) || (by_w + GH <= ty_w + BH);
        tube_hit  = x_ovl && y_out;
        ceil_hit  = by_w < BH;
        floor_hit = by_w + BH > YM;
    end

    always_comb begin
        state_d     = state_q;
        by_d        = by_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        idx_d       = idx_q;
        pend_idx_d  = pend_idx_q;
        tube_acc_d  = tube_acc_q;
        ceil_d      = ceil_q;
        floor_d     = floor_q;
        busy_d      = busy_q;
        scan_done_d = 1'b0;
        game_end_d  = game_end_q;
        hit_idx_d   = hit_idx_q;
        hit_cause_d = hit_cause_q;

        if (bus.restart) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            game_end_d  = 1'b0;
            hit_idx_d   = '0;
            hit_cause_d = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.frame_tick) begin
                        by_d       = bus.bird_y;
                        tx_d       = bus.tube_x;
                        ty_d       = bus.tube_y;
                        idx_d      = '0;
                        pend_idx_d = '0;
                        tube_acc_d = 1'b0;
                        ceil_d     = 1'b0;
                        floor_d    = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = SCAN;
                    end
                end
                SCAN: begin
                    if (tube_hit && !tube_acc_q) begin
                        pend_idx_d = idx_q;
                    end
                    tube_acc_d = tube_acc_q | tube_hit;
                    if (idx_q == '0) begin
                        ceil_d  = ceil_hit;
                        floor_d = floor_hit;
                    end
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                DONE: begin
                    scan_done_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                    if (ceil_q || floor_q || tube_acc_q) begin
                        game_end_d = 1'b1;
                        state_d    = OVER;
                        if (ceil_q) begin
                            hit_cause_d = 2'b10;
                            hit_idx_d   = '0;
                        end else if (floor_q) begin
                            hit_cause_d = 2'b11;
                            hit_idx_d   = '0;
                        end else begin
                            hit_cause_d = 2'b01;
                            hit_idx_d   = pend_idx_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            by_q        <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            idx_q       <= '0;
            pend_idx_q  <= '0;
            tube_acc_q  <= 1'b0;
            ceil_q      <= 1'b0;
            floor_q     <= 1'b0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
            game_end_q  <= 1'b0;
            hit_idx_q   <= '0;
            hit_cause_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            by_q        <= by_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            idx_q       <= idx_d;
            pend_idx_q  <= pend_idx_d;
            tube_acc_q  <= tube_acc_d;
            ceil_q      <= ceil_d;
            floor_q     <= floor_d;
            busy_q      <= busy_d;
            scan_done_q <= scan_done_d;
            game_end_q  <= game_end_d;
            hit_idx_q   <= hit_idx_d;
            hit_cause_q <= hit_cause_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.scan_done = scan_done_q;
    assign bus.game_end  = game_end_q;
    assign bus.hit_idx   = hit_idx_q;
    assign bus.hit_cause = hit_cause_q;
endmodule

// File: tb/tb_collision_scanner.sv
// Bench for collision_scanner: directed corner cases plus randomized frames against a geometric model.
module tb_collision_scanner;
    localparam int N           = 3;
    localparam int W           = 10;
    localparam int BIRD_X      = 364;
    localparam int BIRD_HALF   = 15;
    localparam int TUBE_HALF_W = 30;
    localparam int GAP_HALF    = 30;
    localparam int Y_MAX       = 479;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    collision_scanner_if #(.N_TUBES(N), .W(W)) bus ();

    collision_scanner #(.N_TUBES(N), .W(W)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int m_by;
    int m_tx[N];
    int m_ty[N];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Geometric reference: box distances, priority ceiling > floor > lowest tube.
    function automatic void model(output int cause, output int idx);
        cause = 0;
        idx   = 0;
        if (m_by < BIRD_HALF) cause = 2;
        else if (m_by > Y_MAX - BIRD_HALF) cause = 3;
        else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (iabs(m_tx[i] - BIRD_X) <= BIRD_HALF + TUBE_HALF_W &&
                    iabs(m_by - m_ty[i]) >= GAP_HALF - BIRD_HALF) begin
                    cause = 1;
                    idx   = i;
                end
            end
        end
    endfunction

    task automatic drive_inputs();
        bus.bird_y = m_by[W-1:0];
        for (int i = 0; i < N; i++) begin
            bus.tube_x[i*W +: W] = m_tx[i][W-1:0];
            bus.tube_y[i*W +: W] = m_ty[i][W-1:0];
        end
    endtask

    task automatic scramble();
        bus.bird_y = W'($urandom);
        bus.tube_x = (N*W)'($urandom);
        bus.tube_y = (N*W)'($urandom);
    endtask

    task automatic set_frame(input int by, input int x0, input int x1, input int x2,
                             input int y0, input int y1, input int y2);
        m_by = by;
        m_tx[0] = x0; m_tx[1] = x1; m_tx[2] = x2;
        m_ty[0] = y0; m_ty[1] = y1; m_ty[2] = y2;
    endtask

    task automatic do_scan(input string tag);
        int  cause, idx, lat;
        bit  seen;
        model(cause, idx);
        @(negedge clk);
        drive_inputs();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        scramble();
        check({tag, "_busy"}, int'(bus.busy), 1);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge clk);
            if (bus.scan_done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({tag, "_latency"}, lat, N + 1);
        check({tag, "_game_end"}, int'(bus.game_end), (cause != 0) ? 1 : 0);
        check({tag, "_cause"}, int'(bus.hit_cause), cause);
        check({tag, "_idx"}, int'(bus.hit_idx), idx);
        check({tag, "_busy_done"}, int'(bus.busy), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(bus.scan_done), 0);
    endtask

    task automatic pulse_restart(input string tag);
        @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check({tag, "_rst_game_end"}, int'(bus.game_end), 0);
        check({tag, "_rst_cause"}, int'(bus.hit_cause), 0);
        check({tag, "_rst_idx"}, int'(bus.hit_idx), 0);
    endtask

    function automatic int count_done_dummy(input int x);
        return x;
    endfunction

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.scan_done) cnt++;
        end
    endtask

    initial begin
        int cnt;
        bus.frame_tick = 1'b0;
        bus.restart    = 1'b0;
        bus.bird_y     = '0;
        bus.tube_x     = '0;
        bus.tube_y     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_scan_done", int'(bus.scan_done), 0);
        check("rst_game_end", int'(bus.game_end), 0);
        check("rst_hit_idx", int'(bus.hit_idx), 0);
        check("rst_hit_cause", int'(bus.hit_cause), 0);
        clr_n = 1'b1;

        // Asynchronous reset in the middle of a scan.
        set_frame(240, 364, 100, 600, 240, 240, 240);
        @(negedge clk);
        drive_inputs();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        check("midscan_busy", int'(bus.busy), 1);
        #2 clr_n = 1'b0;
        #1;
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_game_end", int'(bus.game_end), 0);
        #1 clr_n = 1'b1;
        count_dones(8, cnt);
        check("abandoned_no_done", cnt, 0);
        do_scan("after_reset");

        set_frame(240, 364, 100, 600, 240, 240, 240);
        do_scan("no_hit");

        set_frame(240, 364, 100, 600, 200, 240, 240);
        do_scan("tube0_hit");
        // Ticks in OVER are ignored and the verdict holds.
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        count_dones(8, cnt);
        check("over_no_done", cnt, 0);
        check("over_game_end", int'(bus.game_end), 1);
        check("over_cause", int'(bus.hit_cause), 1);
        pulse_restart("tube0");

        set_frame(240, 900, 800, 394, 240, 240, 300);
        do_scan("tube2_hit");
        pulse_restart("tube2");
        do_scan("rescan");
        if (bus.game_end) pulse_restart("rescan");

        set_frame(10, 900, 800, 700, 10, 10, 10);
        do_scan("ceiling");
        pulse_restart("ceiling");
        set_frame(470, 900, 800, 700, 470, 470, 470);
        do_scan("floor");
        pulse_restart("floor");
        set_frame(10, 364, 800, 700, 240, 10, 10);
        do_scan("tube_and_ceiling");
        pulse_restart("tube_and_ceiling");
        set_frame(240, 5, 5, 5, 0, 0, 0);
        do_scan("near_zero_x");
        if (bus.game_end) pulse_restart("near_zero_x");

        // Second tick two edges into a scan must be dropped.
        set_frame(240, 364, 100, 600, 240, 240, 240);
        @(negedge clk);
        drive_inputs();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        count_dones(12, cnt);
        check("double_tick_dones", cnt, 1);

        // Restart and tick together: restart wins.
        @(negedge clk);
        bus.frame_tick = 1'b1;
        bus.restart    = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.restart    = 1'b0;
        check("restart_tick_busy", int'(bus.busy), 0);
        count_dones(8, cnt);
        check("restart_tick_dones", cnt, 0);

        for (int r = 0; r < 30; r++) begin
            m_by = int'($urandom_range(0, 1023));
            if (r % 3 != 0) m_by = int'($urandom_range(20, 460));
            for (int i = 0; i < N; i++) begin
                m_tx[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(300, 430))
                                                     : int'($urandom_range(0, 1023));
                m_ty[i] = (m_by + int'($urandom_range(0, 40)) - 20 + 1024) % 1024;
            end
            do_scan($sformatf("rand%0d", r));
            if (bus.game_end) pulse_restart($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
